// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    // FSM encoding; 2'd3 is unreachable and decodes as idle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit combinational full adder cell shared by every bit position.
module serial_add_ctrl_full_adder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through
// one full adder cell, one bit per clock, with start/busy/done handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             CI_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CO_OUT,
    output logic             OVF
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, sum_sr_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q, ovf_q;

    logic accept;
    logic last;
    logic fa_s, fa_co;

    serial_add_ctrl_full_adder u_fa (
        .A  (op_a_q[0]),
        .B  (op_b_q[0]),
        .Ci (carry_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    // Next-state decode; START is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            StRun: begin
                if (cnt_q == LastCnt) begin
                    last    = 1'b1;
                    state_d = StDone;
                end
            end
            default: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/sum shift registers, carry flop and bit counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            op_a_q  <= A_IN;
            op_b_q  <= B_IN;
            carry_q <= CI_IN;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            op_a_q   <= op_a_q >> 1;
            op_b_q   <= op_b_q >> 1;
            sum_sr_q <= {fa_s, sum_sr_q[WIDTH-1:1]};
            carry_q  <= fa_co;
            // Hold on the final bit so the counter never wraps.
            if (!last) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    // Result registers update only on the completion edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (last) begin
            sum_q <= {fa_s, sum_sr_q[WIDTH-1:1]};
            co_q  <= fa_co;
            ovf_q <= carry_q ^ fa_co;
        end
    end

    assign BUSY   = (state_q == StRun);
    assign DONE   = (state_q == StDone);
    assign SUM    = sum_q;
    assign CO_OUT = co_q;
    assign OVF    = ovf_q;

endmodule
